// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse symbol, letter, reference-pattern and FSM definitions
// Purpose: constants shared by the decoder, its pattern matcher and the encoder LUT.
// Ports: none (package).
package morse_pkg;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam logic [2:0] LTR_A = 3'd0;
    localparam logic [2:0] LTR_B = 3'd1;
    localparam logic [2:0] LTR_C = 3'd2;
    localparam logic [2:0] LTR_D = 3'd3;
    localparam logic [2:0] LTR_E = 3'd4;
    localparam logic [2:0] LTR_F = 3'd5;
    localparam logic [2:0] LTR_G = 3'd6;
    localparam logic [2:0] LTR_H = 3'd7;

    localparam int PAT_W = 4;

    // Symbol i lives in bit i (first symbol in bit 0); 1 = dash, 0 = dot.
    localparam logic [PAT_W-1:0] REF_PAT [8] = '{
        4'b0010,    // A  .-
        4'b0001,    // B  -...
        4'b0101,    // C  -.-.
        4'b0001,    // D  -..
        4'b0000,    // E  .
        4'b0100,    // F  ..-.
        4'b0011,    // G  --.
        4'b0000     // H  ....
    };

    localparam logic [2:0] REF_LEN [8] = '{
        3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/morse_pattern_match.sv
// rtl/morse_pattern_match.sv - combinational lookup of a dot/dash pattern to a letter index
// Purpose: compares the accumulated symbols against the reference table.
// Ports: pattern (symbols, bit0 first), nsym (symbol count) -> code (letter index), hit (match found).
module morse_pattern_match
    import morse_pkg::*;
#(
    parameter int MAX_SYMBOLS = 4,
    parameter int NSYM_W      = $clog2(MAX_SYMBOLS + 1)
) (
    input  logic [MAX_SYMBOLS-1:0] pattern,
    input  logic [NSYM_W-1:0]      nsym,
    output logic [2:0]             code,
    output logic                   hit
);

    logic [MAX_SYMBOLS-1:0] masked;

    always_comb begin
        // Bits above nsym are not part of the letter.
        masked = '0;
        for (int j = 0; j < MAX_SYMBOLS; j++) begin
            masked[j] = pattern[j] & (j < int'(nsym));
        end
        code = '0;
        hit  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (nsym == NSYM_W'(REF_LEN[i]) && masked == MAX_SYMBOLS'(REF_PAT[i])) begin
                code = 3'(i);
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - Morse line receiver decoding letters A..H
// Purpose: measures mark/space runs per tick, builds a dot/dash pattern, decodes at the letter gap.
// Ports: clk, reset (async, active-high), tick (sample strobe), serial_in (1=mark)
//        -> letter_valid / letter_error (1-clk pulses), letter_code (held index), busy (FSM not idle).
module morse_decoder
    import morse_pkg::*;
#(
    parameter int DASH_TICKS  = 3,
    parameter int LETTER_GAP  = 3,
    parameter int MAX_SYMBOLS = 4,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       serial_in,
    output logic       letter_valid,
    output logic [2:0] letter_code,
    output logic       letter_error,
    output logic       busy
);

    localparam int NSYM_W = $clog2(MAX_SYMBOLS + 1);
    localparam int IDX_W  = (MAX_SYMBOLS > 1) ? $clog2(MAX_SYMBOLS) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  DASH_CNT  = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0]  GAP_CNT   = CNT_W'(LETTER_GAP);
    localparam logic [NSYM_W-1:0] SYM_LIMIT = NSYM_W'(MAX_SYMBOLS);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       mark_cnt, mark_cnt_n;
    logic [CNT_W-1:0]       space_cnt, space_cnt_n;
    logic [CNT_W-1:0]       mark_inc, space_inc;
    logic [MAX_SYMBOLS-1:0] pattern, pattern_n;
    logic [NSYM_W-1:0]      nsym, nsym_n;
    // Letter end is sampled on one edge and reported on the next.
    logic                   eval_q, eval_n;
    logic                   flush_q, flush_n;
    logic [2:0]             match_code;
    logic                   match_hit;

    morse_pattern_match #(
        .MAX_SYMBOLS (MAX_SYMBOLS),
        .NSYM_W      (NSYM_W)
    ) u_match (
        .pattern (pattern),
        .nsym    (nsym),
        .code    (match_code),
        .hit     (match_hit)
    );

    assign mark_inc  = (mark_cnt  == CNT_MAX) ? mark_cnt  : mark_cnt  + 1'b1;
    assign space_inc = (space_cnt == CNT_MAX) ? space_cnt : space_cnt + 1'b1;
    assign busy      = (state != IDLE);

    always_comb begin
        state_n     = state;
        mark_cnt_n  = mark_cnt;
        space_cnt_n = space_cnt;
        pattern_n   = pattern;
        nsym_n      = nsym;
        eval_n      = 1'b0;
        flush_n     = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (serial_in) begin
                        state_n     = MARK;
                        mark_cnt_n  = CNT_ONE;
                        space_cnt_n = '0;
                        pattern_n   = '0;
                        nsym_n      = '0;
                    end
                end
                MARK: begin
                    if (serial_in) begin
                        mark_cnt_n = mark_inc;
                    end else if ((mark_cnt == CNT_ONE || mark_cnt == DASH_CNT) && nsym < SYM_LIMIT) begin
                        pattern_n[nsym[IDX_W-1:0]] = (mark_cnt == CNT_ONE) ? DOT : DASH;
                        nsym_n      = nsym + 1'b1;
                        state_n     = SPACE;
                        space_cnt_n = CNT_ONE;
                    end else begin
                        // Bad mark length or symbol overflow; this sample is already a space.
                        state_n     = FLUSH;
                        space_cnt_n = CNT_ONE;
                    end
                end
                SPACE: begin
                    if (!serial_in) begin
                        space_cnt_n = space_inc;
                        if (space_inc == GAP_CNT) begin
                            state_n = IDLE;
                            eval_n  = 1'b1;
                        end
                    end else if (space_cnt == CNT_ONE) begin
                        state_n    = MARK;
                        mark_cnt_n = CNT_ONE;
                    end else begin
                        state_n     = FLUSH;
                        space_cnt_n = '0;
                    end
                end
                FLUSH: begin
                    if (serial_in) begin
                        space_cnt_n = '0;
                    end else begin
                        space_cnt_n = space_inc;
                        if (space_inc == GAP_CNT) begin
                            state_n = IDLE;
                            flush_n = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mark_cnt     <= '0;
            space_cnt    <= '0;
            pattern      <= '0;
            nsym         <= '0;
            eval_q       <= 1'b0;
            flush_q      <= 1'b0;
            letter_valid <= 1'b0;
            letter_error <= 1'b0;
            letter_code  <= '0;
        end else begin
            state        <= state_n;
            mark_cnt     <= mark_cnt_n;
            space_cnt    <= space_cnt_n;
            pattern      <= pattern_n;
            nsym         <= nsym_n;
            eval_q       <= eval_n;
            flush_q      <= flush_n;
            letter_valid <= eval_q & match_hit;
            letter_error <= flush_q | (eval_q & ~match_hit);
            if (eval_q && match_hit) begin
                letter_code <= match_code;
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - directed self-checking bench for morse_decoder
module tb_morse_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       serial_in;
    logic       letter_valid;
    logic [2:0] letter_code;
    logic       letter_error;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int error_cnt = 0;
    int overlap_cnt = 0;
    int v0, e0;

    morse_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .serial_in    (serial_in),
        .letter_valid (letter_valid),
        .letter_code  (letter_code),
        .letter_error (letter_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (letter_valid === 1'b1) valid_cnt++;
        if (letter_error === 1'b1) error_cnt++;
        if (letter_valid === 1'b1 && letter_error === 1'b1) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends n bits MSB first, one tick each, with gap tick-free clocks after every tick.
    task automatic send_seq(input logic [15:0] bits, input int n, input int gap, input logic tog);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) begin
            serial_in = b[i];
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            for (int k = 0; k < gap; k++) begin
                if (tog) serial_in = ~serial_in;
                @(negedge clk);
            end
        end
    endtask

    task automatic mark_counts;
        v0 = valid_cnt;
        e0 = error_cnt;
    endtask

    task automatic settle;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 8'(letter_valid), 8'd0);
        check("rst_error", 8'(letter_error), 8'd0);
        check("rst_code",  8'(letter_code),  8'd0);
        check("rst_busy",  8'(busy),         8'd0);
        reset = 1'b0;
        @(negedge clk);

        // A: .-  with exact pulse latency
        mark_counts();
        send_seq(16'b10111000, 8, 0, 1'b0);
        check("a_no_early_valid", 8'(letter_valid), 8'd0);
        check("a_busy_low", 8'(busy), 8'd0);
        @(negedge clk);
        check("a_valid_pulse", 8'(letter_valid), 8'd1);
        check("a_code", 8'(letter_code), 8'd0);
        @(negedge clk);
        check("a_valid_one_clk", 8'(letter_valid), 8'd0);
        settle();
        check("a_valid_count", 8'(valid_cnt - v0), 8'd1);
        check("a_error_count", 8'(error_cnt - e0), 8'd0);

        // B: -...
        mark_counts();
        send_seq(16'b111010101000, 12, 0, 1'b0);
        settle();
        check("b_valid_count", 8'(valid_cnt - v0), 8'd1);
        check("b_code", 8'(letter_code), 8'd1);

        // H: ....
        mark_counts();
        send_seq(16'b1010101000, 10, 0, 1'b0);
        settle();
        check("h_valid_count", 8'(valid_cnt - v0), 8'd1);
        check("h_code", 8'(letter_code), 8'd7);

        // Two-tick mark is malformed
        mark_counts();
        send_seq(16'b11000, 5, 0, 1'b0);
        check("len2_no_early_error", 8'(letter_error), 8'd0);
        @(negedge clk);
        check("len2_error_pulse", 8'(letter_error), 8'd1);
        settle();
        check("len2_error_count", 8'(error_cnt - e0), 8'd1);
        check("len2_valid_count", 8'(valid_cnt - v0), 8'd0);
        check("len2_code_held", 8'(letter_code), 8'd7);

        // Five dots overflow the symbol store
        mark_counts();
        send_seq(16'b101010101000, 12, 0, 1'b0);
        settle();
        check("ovf_error_count", 8'(error_cnt - e0), 8'd1);
        check("ovf_valid_count", 8'(valid_cnt - v0), 8'd0);

        // -- has no entry in the table
        mark_counts();
        send_seq(16'b1110111000, 10, 0, 1'b0);
        settle();
        check("mm_error_count", 8'(error_cnt - e0), 8'd1);
        check("mm_valid_count", 8'(valid_cnt - v0), 8'd0);
        check("mm_code_held", 8'(letter_code), 8'd7);

        // A with tick every 7 clk and the line toggling between ticks
        mark_counts();
        send_seq(16'b10111000, 8, 6, 1'b1);
        serial_in = 1'b0;
        settle();
        check("slow_valid_count", 8'(valid_cnt - v0), 8'd1);
        check("slow_error_count", 8'(error_cnt - e0), 8'd0);
        check("slow_code", 8'(letter_code), 8'd0);

        // Reset mid-letter, with a tick landing during reset
        mark_counts();
        send_seq(16'b101, 3, 0, 1'b0);
        check("mid_busy_before", 8'(busy), 8'd1);
        reset = 1'b1;
        #1;
        check("mid_busy_reset", 8'(busy), 8'd0);
        serial_in = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        reset = 1'b0;
        check("mid_busy_after", 8'(busy), 8'd0);
        send_seq(16'b000, 3, 0, 1'b0);
        settle();
        check("mid_valid_count", 8'(valid_cnt - v0), 8'd0);
        check("mid_error_count", 8'(error_cnt - e0), 8'd0);

        // Idle all-zero line
        mark_counts();
        send_seq(16'b000000, 6, 0, 1'b0);
        settle();
        check("idle_busy", 8'(busy), 8'd0);
        check("idle_pulses", 8'((valid_cnt - v0) + (error_cnt - e0)), 8'd0);

        check("no_overlap", 8'(overlap_cnt), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
